multicycle_controller: RTL and testbench

Single-clock multicycle sequencer for the ARMv8 fetch/decode/execute datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and issues the PC, IR, register-file, ALU and data-memory strobes in the correct cycle. It consumes the decoder control bits and the ALU zero flag, and it replaces the delayed-clock phase chain used for stage timing.

---
 rtl/multicycle_controller_if.sv | 50 +++++
 rtl/multicycle_controller.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Handshake bundle between the multicycle sequencer and the datapath:
// decoder/ALU/memory status in, stage strobes and status counters out.
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    // Sequencing requests
    logic             start;
    logic             halt_req;
    // Decoder class bits and datapath status
    logic             uncondbranch;
    logic             branch;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_zero;
    logic             dmem_ack;
    // Stage strobes
    logic             pc_write;
    logic             pc_src;
    logic             ir_write;
    logic             alu_en;
    logic             dmem_req;
    logic             dmem_we;
    logic             rf_write_en;
    logic             wb_sel;
    // Status
    logic [2:0]       state;
    logic             busy;
    logic             mem_error;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    // Datapath / host side
    modport master (
        output start, halt_req, uncondbranch, branch, mem_read, mem_write,
               mem_to_reg, alu_zero, dmem_ack,
        input  pc_write, pc_src, ir_write, alu_en, dmem_req, dmem_we,
               rf_write_en, wb_sel, state, busy, mem_error, instr_count,
               cycle_count
    );

    // Sequencer side
    modport slave (
        input  start, halt_req, uncondbranch, branch, mem_read, mem_write,
               mem_to_reg, alu_zero, dmem_ack,
        output pc_write, pc_src, ir_write, alu_en, dmem_req, dmem_we,
               rf_write_en, wb_sel, state, busy, mem_error, instr_count,
               cycle_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle sequencer: walks each instruction through FETCH, DECODE,
// EXECUTE, optional MEMORY and WRITEBACK, issuing the datapath strobes
// from the registered state plus the class bits latched in DECODE.
module multicycle_controller #(
    parameter int WORD        = 64,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.slave bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEMORY    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_ERROR     = 3'd6;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    // The sequencer is width-agnostic; WORD is carried only so the
    // instantiation matches the datapath it is paired with.
    if (WORD < 1) begin : g_word_invalid
    end

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic              uc_reg;
    logic              br_reg;
    logic              ld_reg;
    logic              st_reg;
    logic              wb_sel_reg;
    logic              halt_pending_reg;
    logic              mem_error_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0]  instr_count_reg;
    logic [CNT_W-1:0]  cycle_count_reg;
    logic              retire;
    logic              busy;
    logic              wait_expired;

    assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_ERROR);
    // The counter holds the number of completed MEMORY cycles, so the
    // last permitted cycle is the one where it reads MEM_TIMEOUT-1.
    assign wait_expired = (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state selection and retirement detection
    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) state_next = ST_FETCH;
            end
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                if (bus.mem_read && bus.mem_write) state_next = ST_ERROR;
                else                               state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (uc_reg || br_reg)      retire     = 1'b1;
                else if (ld_reg || st_reg) state_next = ST_MEMORY;
                else                       state_next = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                // An ack in the final permitted cycle still wins over timeout
                if (bus.dmem_ack) begin
                    if (ld_reg) state_next = ST_WRITEBACK;
                    else        retire     = 1'b1;
                end else if (wait_expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_WRITEBACK: retire = 1'b1;
            ST_ERROR:     state_next = ST_ERROR;
            default:      state_next = ST_IDLE;
        endcase
        if (retire) begin
            state_next = (halt_pending_reg || bus.halt_req) ? ST_IDLE : ST_FETCH;
        end
    end

    // Strobe decode from state and latched class bits
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.pc_src      = 1'b0;
        bus.ir_write    = 1'b0;
        bus.alu_en      = 1'b0;
        bus.dmem_req    = 1'b0;
        bus.dmem_we     = 1'b0;
        bus.rf_write_en = 1'b0;
        case (state_reg)
            ST_FETCH: bus.ir_write = 1'b1;
            ST_EXECUTE: begin
                bus.alu_en = 1'b1;
                if (uc_reg) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 1'b1;
                end else if (br_reg) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = bus.alu_zero;
                end
            end
            ST_MEMORY: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = st_reg;
                bus.pc_write = st_reg && bus.dmem_ack;
            end
            ST_WRITEBACK: begin
                bus.rf_write_en = 1'b1;
                bus.pc_write    = 1'b1;
            end
            default: ;
        endcase
    end

    // State register and sticky error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            mem_error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next == ST_ERROR) mem_error_reg <= 1'b1;
        end
    end

    // Instruction class bits captured once per instruction in DECODE
    always_ff @(posedge clk) begin
        if (!reset) begin
            uc_reg     <= 1'b0;
            br_reg     <= 1'b0;
            ld_reg     <= 1'b0;
            st_reg     <= 1'b0;
            wb_sel_reg <= 1'b0;
        end else if (state_reg == ST_DECODE) begin
            uc_reg     <= bus.uncondbranch;
            br_reg     <= bus.branch;
            ld_reg     <= bus.mem_read;
            st_reg     <= bus.mem_write;
            wb_sel_reg <= bus.mem_to_reg;
        end
    end

    // Memory wait counter, restarted whenever MEMORY is not occupied
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_MEMORY) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    // Halt request capture; a start+halt in IDLE arms it for one instruction
    always_ff @(posedge clk) begin
        if (!reset) begin
            halt_pending_reg <= 1'b0;
        end else if (state_next == ST_IDLE) begin
            halt_pending_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && bus.start) begin
            halt_pending_reg <= bus.halt_req;
        end else if (busy) begin
            halt_pending_reg <= halt_pending_reg | bus.halt_req;
        end
    end

    // Retired-instruction and busy-cycle counters, both free-wrapping
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_count_reg <= '0;
            cycle_count_reg <= '0;
        end else begin
            if (retire) instr_count_reg <= instr_count_reg + 1'b1;
            if (busy)   cycle_count_reg <= cycle_count_reg + 1'b1;
        end
    end

    assign bus.wb_sel      = wb_sel_reg;
    assign bus.state       = state_reg;
    assign bus.busy        = busy;
    assign bus.mem_error   = mem_error_reg;
    assign bus.instr_count = instr_count_reg;
    assign bus.cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each task walks one scenario
// cycle by cycle and compares state, strobes and counters on the falling edge.
module tb_multicycle_controller;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    multicycle_controller_if #(.CNT_W(32)) bus ();

    multicycle_controller #(
        .WORD(64),
        .CNT_W(32),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, pc_src, ir_write, alu_en, dmem_req, dmem_we, rf_write_en}
    function automatic logic [6:0] strobes();
        return {bus.pc_write, bus.pc_src, bus.ir_write, bus.alu_en,
                bus.dmem_req, bus.dmem_we, bus.rf_write_en};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.start        = 1'b0;
        bus.halt_req     = 1'b0;
        bus.uncondbranch = 1'b0;
        bus.branch       = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.alu_zero     = 1'b0;
        bus.dmem_ack     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        total_cnt++;
        if (bus.state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", bus.state);
        else pass_cnt++;
        total_cnt++;
        if (strobes() !== 7'b0) $display("FAIL reset_strobes: got %b expected 0000000", strobes());
        else pass_cnt++;
        total_cnt++;
        if (bus.instr_count !== 32'd0 || bus.cycle_count !== 32'd0)
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.instr_count, bus.cycle_count);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.mem_error !== 1'b0 || bus.wb_sel !== 1'b0)
            $display("FAIL reset_flags: got busy=%b err=%b wb=%b expected 000", bus.busy, bus.mem_error, bus.wb_sel);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_alu_op();
        do_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total_cnt++;
        if (bus.state !== 3'd1 || strobes() !== 7'b0010000)
            $display("FAIL alu_fetch: got st=%0d strb=%b expected st=1 strb=0010000", bus.state, strobes());
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.state !== 3'd2 || strobes() !== 7'b0000000)
            $display("FAIL alu_decode: got st=%0d strb=%b expected st=2 strb=0000000", bus.state, strobes());
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.state !== 3'd3 || strobes() !== 7'b0001000)
            $display("FAIL alu_execute: got st=%0d strb=%b expected st=3 strb=0001000", bus.state, strobes());
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.state !== 3'd5 || strobes() !== 7'b1000001)
            $display("FAIL alu_writeback: got st=%0d strb=%b expected st=5 strb=1000001", bus.state, strobes());
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.state !== 3'd1 || bus.instr_count !== 32'd1 || bus.cycle_count !== 32'd4)
            $display("FAIL alu_retire: got st=%0d ic=%0d cc=%0d expected st=1 ic=1 cc=4",
                     bus.state, bus.instr_count, bus.cycle_count);
        else pass_cnt++;
        $display("test_alu_op done");
    endtask

    task automatic test_cbz();
        do_reset();
        bus.branch   = 1'b1;
        bus.alu_zero = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (bus.state !== 3'd3 || strobes() !== 7'b1101000)
            $display("FAIL cbz_taken: got st=%0d strb=%b expected st=3 strb=1101000", bus.state, strobes());
        else pass_cnt++;
        // pc_src tracks alu_zero within the EXECUTE cycle
        bus.alu_zero = 1'b0;
        #1;
        total_cnt++;
        if (bus.pc_src !== 1'b0) $display("FAIL cbz_pcsrc_comb: got %b expected 0", bus.pc_src);
        else pass_cnt++;
        bus.alu_zero = 1'b1;
        tick();
        total_cnt++;
        if (bus.state !== 3'd1 || bus.instr_count !== 32'd1)
            $display("FAIL cbz_first_retire: got st=%0d ic=%0d expected st=1 ic=1", bus.state, bus.instr_count);
        else pass_cnt++;
        bus.alu_zero = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (bus.state !== 3'd3 || strobes() !== 7'b1001000)
            $display("FAIL cbz_not_taken: got st=%0d strb=%b expected st=3 strb=1001000", bus.state, strobes());
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.state !== 3'd1 || bus.instr_count !== 32'd2 || bus.cycle_count !== 32'd6)
            $display("FAIL cbz_second_retire: got st=%0d ic=%0d cc=%0d expected st=1 ic=2 cc=6",
                     bus.state, bus.instr_count, bus.cycle_count);
        else pass_cnt++;
        $display("test_cbz done");
    endtask

    task automatic test_load();
        int req_cycles;
        do_reset();
        bus.mem_read   = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        req_cycles = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 3) bus.dmem_ack = 1'b1;
            #1;
            if (bus.state == 3'd4 && strobes() == 7'b0000100) req_cycles++;
        end
        total_cnt++;
        if (req_cycles !== 3) $display("FAIL load_req_cycles: got %0d expected 3", req_cycles);
        else pass_cnt++;
        tick();
        bus.dmem_ack = 1'b0;
        total_cnt++;
        if (bus.state !== 3'd5 || strobes() !== 7'b1000001 || bus.wb_sel !== 1'b1)
            $display("FAIL load_writeback: got st=%0d strb=%b wb=%b expected st=5 strb=1000001 wb=1",
                     bus.state, strobes(), bus.wb_sel);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.state !== 3'd1 || bus.instr_count !== 32'd1 || bus.cycle_count !== 32'd7)
            $display("FAIL load_retire: got st=%0d ic=%0d cc=%0d expected st=1 ic=1 cc=7",
                     bus.state, bus.instr_count, bus.cycle_count);
        else pass_cnt++;
        $display("test_load done");
    endtask

    task automatic test_store();
        do_reset();
        bus.mem_write = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.dmem_ack = 1'b1;
        #1;
        total_cnt++;
        if (bus.state !== 3'd4 || strobes() !== 7'b1000110)
            $display("FAIL store_memory: got st=%0d strb=%b expected st=4 strb=1000110", bus.state, strobes());
        else pass_cnt++;
        tick();
        bus.dmem_ack = 1'b0;
        total_cnt++;
        if (bus.state !== 3'd1 || bus.instr_count !== 32'd1 || bus.cycle_count !== 32'd4 || bus.wb_sel !== 1'b0)
            $display("FAIL store_retire: got st=%0d ic=%0d cc=%0d wb=%b expected st=1 ic=1 cc=4 wb=0",
                     bus.state, bus.instr_count, bus.cycle_count, bus.wb_sel);
        else pass_cnt++;
        $display("test_store done");
    endtask

    task automatic test_timeout();
        int mem_cycles;
        do_reset();
        bus.mem_read = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        mem_cycles = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (bus.state == 3'd4) mem_cycles++;
        end
        total_cnt++;
        if (mem_cycles !== 15) $display("FAIL timeout_mem_cycles: got %0d expected 15", mem_cycles);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.state !== 3'd6 || bus.mem_error !== 1'b1 || bus.busy !== 1'b0 || strobes() !== 7'b0)
            $display("FAIL timeout_error: got st=%0d err=%b busy=%b strb=%b expected st=6 err=1 busy=0 strb=0000000",
                     bus.state, bus.mem_error, bus.busy, strobes());
        else pass_cnt++;
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        bus.start = 1'b0;
        total_cnt++;
        if (bus.state !== 3'd6 || bus.mem_error !== 1'b1 || bus.cycle_count !== 32'd18 || bus.instr_count !== 32'd0)
            $display("FAIL timeout_sticky: got st=%0d err=%b cc=%0d ic=%0d expected st=6 err=1 cc=18 ic=0",
                     bus.state, bus.mem_error, bus.cycle_count, bus.instr_count);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total_cnt++;
        if (bus.state !== 3'd0 || bus.mem_error !== 1'b0)
            $display("FAIL timeout_reset_clear: got st=%0d err=%b expected st=0 err=0", bus.state, bus.mem_error);
        else pass_cnt++;
        $display("test_timeout done");
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        bus.mem_read = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 15) bus.dmem_ack = 1'b1;
        end
        tick();
        bus.dmem_ack = 1'b0;
        total_cnt++;
        if (bus.state !== 3'd5 || bus.mem_error !== 1'b0)
            $display("FAIL ack_at_limit: got st=%0d err=%b expected st=5 err=0", bus.state, bus.mem_error);
        else pass_cnt++;
        $display("test_ack_at_limit done");
    endtask

    task automatic test_illegal_decode();
        do_reset();
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (bus.state !== 3'd6 || bus.mem_error !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL illegal_decode: got st=%0d err=%b busy=%b expected st=6 err=1 busy=0",
                     bus.state, bus.mem_error, bus.busy);
        else pass_cnt++;
        $display("test_illegal_decode done");
    endtask

    task automatic test_halt();
        do_reset();
        bus.start    = 1'b1;
        bus.halt_req = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.halt_req = 1'b0;
        tick();
        tick();
        tick();
        tick();
        total_cnt++;
        if (bus.state !== 3'd0 || bus.instr_count !== 32'd1 || bus.busy !== 1'b0)
            $display("FAIL halt_with_start: got st=%0d ic=%0d busy=%b expected st=0 ic=1 busy=0",
                     bus.state, bus.instr_count, bus.busy);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (bus.state !== 3'd0 || bus.instr_count !== 32'd1)
            $display("FAIL halt_stays_idle: got st=%0d ic=%0d expected st=0 ic=1", bus.state, bus.instr_count);
        else pass_cnt++;
        // A halt raised mid-instruction stops at the following retirement
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        tick();
        total_cnt++;
        if (bus.state !== 3'd0 || bus.instr_count !== 32'd2 || bus.cycle_count !== 32'd8)
            $display("FAIL halt_mid_instr: got st=%0d ic=%0d cc=%0d expected st=0 ic=2 cc=8",
                     bus.state, bus.instr_count, bus.cycle_count);
        else pass_cnt++;
        $display("test_halt done");
    endtask

    task automatic test_reset_mid_memory();
        do_reset();
        bus.mem_read = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        total_cnt++;
        if (bus.state !== 3'd4 || bus.dmem_req !== 1'b1)
            $display("FAIL midreset_in_memory: got st=%0d req=%b expected st=4 req=1", bus.state, bus.dmem_req);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total_cnt++;
        if (bus.state !== 3'd0 || bus.dmem_req !== 1'b0 || bus.instr_count !== 32'd0)
            $display("FAIL midreset_abandon: got st=%0d req=%b ic=%0d expected st=0 req=0 ic=0",
                     bus.state, bus.dmem_req, bus.instr_count);
        else pass_cnt++;
        $display("test_reset_mid_memory done");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        clear_inputs();
        test_reset();
        test_alu_op();
        test_cbz();
        test_load();
        test_store();
        test_timeout();
        test_ack_at_limit();
        test_illegal_decode();
        test_halt();
        test_reset_mid_memory();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
